random_led_frame_gen: RTL and testbench

Parametrised successor to the fixed 5-LED random game-LED controller. Picks a pseudo-random target LED out of N_LEDS and builds a packed colour frame with only that LED lit. Supports static, blink and fade display modes, and hands each frame to the WS2811 array serializer over a valid/ready handshake. Sits between the colour mixer and the array driver in the game datapath.

---
 rtl/random_led_frame_gen.sv | 157 +++++++++++++++
 tb/tb_random_led_frame_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_led_frame_gen.sv
// Random single-LED frame generator: picks a pseudo-random LED and offers a
// packed colour frame (static, blink or fade) to the array serializer.
module random_led_frame_gen #(
  parameter int          N_LEDS    = 5,
  parameter int          CH_W      = 8,
  parameter int          SEL_W     = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          NO_REPEAT = 1,
  parameter int          FADE_STEP = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     gerar_jogada,
  input  logic                     tick,
  input  logic [1:0]               modo,
  input  logic [3*CH_W-1:0]        cor_led,
  input  logic                     frame_ready,
  output logic                     frame_valid,
  output logic [N_LEDS*3*CH_W-1:0] frame,
  output logic [SEL_W-1:0]         position_led,
  output logic                     busy
);

  localparam int              PIX_W    = 3*CH_W;
  localparam logic [15:0]     SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [SEL_W:0]  N_SEL    = (SEL_W+1)'(N_LEDS);
  localparam logic [SEL_W-1:0] LAST_POS = SEL_W'(N_LEDS-1);
  localparam logic [4:0]      MAX_RETRY = 5'd16;

  typedef enum logic [1:0] {IDLE, PICK, LOAD, WAIT_ACK} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [CH_W-1:0]  lvl;
  logic             phase;
  logic             pend_j;
  logic             pend_r;
  logic [4:0]       retry;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] next_pos;
  logic             cand_ok;
  logic [PIX_W-1:0] lit;
  logic [N_LEDS*PIX_W-1:0] next_frame;

  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] cin,
                                               input logic [CH_W-1:0] l);
    logic [2*CH_W:0] prod;
    prod = (2*CH_W+1)'(cin) * ((2*CH_W+1)'(l) + (2*CH_W+1)'(1));
    return CH_W'(prod >> CH_W);
  endfunction

  function automatic logic [CH_W-1:0] fade_dec(input logic [CH_W-1:0] l);
    int v;
    v = int'(l) - FADE_STEP;
    return (v <= 0) ? '0 : CH_W'(v);
  endfunction

  function automatic logic [PIX_W-1:0] scale_pix(input logic [PIX_W-1:0] cin,
                                                 input logic [1:0] m,
                                                 input logic ph,
                                                 input logic [CH_W-1:0] l);
    logic [PIX_W-1:0] px;
    px = cin;
    for (int j = 0; j < 3; j++) begin
      case (m)
        2'b01:   px[j*CH_W +: CH_W] = ph ? cin[j*CH_W +: CH_W] : '0;
        2'b10:   px[j*CH_W +: CH_W] = fade_ch(cin[j*CH_W +: CH_W], l);
        default: px[j*CH_W +: CH_W] = cin[j*CH_W +: CH_W];
      endcase
    end
    return px;
  endfunction

  // Galois form of x^16+x^14+x^13+x^11+1, free-running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    cand     = lfsr[SEL_W-1:0];
    cand_ok  = ({1'b0, cand} < N_SEL) && !((NO_REPEAT != 0) && (cand == position_led));
    next_pos = (position_led == LAST_POS) ? '0 : position_led + 1'b1;
    lit      = scale_pix(cor_led, modo, phase, lvl);
    next_frame = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (position_led == SEL_W'(i)) next_frame[i*PIX_W +: PIX_W] = lit;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      frame        <= '0;
      frame_valid  <= 1'b0;
      position_led <= '0;
      busy         <= 1'b0;
      lvl          <= '1;
      phase        <= 1'b1;
      pend_j       <= 1'b0;
      pend_r       <= 1'b0;
      retry        <= '0;
    end else begin
      if (state != IDLE) begin
        if (gerar_jogada) pend_j <= 1'b1;
        if (tick)         pend_r <= 1'b1;
      end
      case (state)
        IDLE: begin
          // a pick resets lvl/phase, so any coincident refresh is dropped
          if (gerar_jogada || pend_j) begin
            pend_j <= 1'b0;
            pend_r <= 1'b0;
            busy   <= 1'b1;
            state  <= PICK;
          end else if (tick || pend_r) begin
            pend_r <= 1'b0;
            if (modo == 2'b01) begin
              phase <= ~phase;
              busy  <= 1'b1;
              state <= LOAD;
            end else if (modo == 2'b10) begin
              lvl   <= fade_dec(lvl);
              busy  <= 1'b1;
              state <= LOAD;
            end
          end
        end
        PICK: begin
          if (retry == MAX_RETRY || cand_ok) begin
            position_led <= (retry == MAX_RETRY) ? next_pos : cand;
            lvl          <= '1;
            phase        <= 1'b1;
            retry        <= '0;
            state        <= LOAD;
          end else begin
            retry <= retry + 5'd1;
          end
        end
        LOAD: begin
          frame       <= next_frame;
          frame_valid <= 1'b1;
          state       <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_random_led_frame_gen.sv
// Scoreboard bench for random_led_frame_gen: a 5-LED instance (fade step 64)
// and a 2-LED instance for alternation and retry fallback.
module tb_random_led_frame_gen;
  typedef struct { logic is_pick; logic [23:0] pix; } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         rst_a = 1'b0, gj_a = 1'b0, tick_a = 1'b0, ready_a = 1'b1;
  logic [1:0]   modo_a = 2'b00;
  logic [23:0]  cor_a = 24'hFF8040;
  logic         valid_a, busy_a;
  logic [119:0] frame_a;
  logic [2:0]   pos_a;

  logic         rst_b = 1'b0, gj_b = 1'b0, tick_b = 1'b0, ready_b = 1'b1;
  logic [1:0]   modo_b = 2'b00;
  logic [23:0]  cor_b = 24'h123456;
  logic         valid_b, busy_b;
  logic [47:0]  frame_b;
  logic [0:0]   pos_b;

  random_led_frame_gen #(.N_LEDS(5), .CH_W(8), .SEL_W(3), .LFSR_SEED(16'hACE1),
                         .NO_REPEAT(1), .FADE_STEP(64)) dut_a (
    .clock(clock), .reset(rst_a), .gerar_jogada(gj_a), .tick(tick_a), .modo(modo_a),
    .cor_led(cor_a), .frame_ready(ready_a), .frame_valid(valid_a), .frame(frame_a),
    .position_led(pos_a), .busy(busy_a));

  random_led_frame_gen #(.N_LEDS(2), .CH_W(8), .SEL_W(1), .LFSR_SEED(16'h1D2B),
                         .NO_REPEAT(1), .FADE_STEP(16)) dut_b (
    .clock(clock), .reset(rst_b), .gerar_jogada(gj_b), .tick(tick_b), .modo(modo_b),
    .cor_led(cor_b), .frame_ready(ready_b), .frame_valid(valid_b), .frame(frame_b),
    .position_led(pos_b), .busy(busy_b));

  int         vectors = 0;
  int         miscompares = 0;
  int         frames_a = 0;
  int         frames_b = 0;
  int         hist[5];
  exp_t       qa[$];
  logic [0:0] qb[$];
  logic [2:0] last_pos_a = 3'd0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input logic [127:0] act,
                            input string req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %s", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor A: checks every accepted frame against the next queued expectation
  always @(negedge clock) begin
    exp_t e;
    if (!rst_a) begin
      qa.delete();
      last_pos_a = 3'd0;
    end else if (valid_a && ready_a) begin
      frames_a++;
      check_cond("a_frame_expected", qa.size() != 0, frame_a, "a queued expectation");
      if (qa.size() != 0) begin
        e = qa.pop_front();
        if (e.is_pick) begin
          check_cond("a_pick_range", pos_a < 3'd5, pos_a, "0..4");
          check_cond("a_pick_no_repeat", pos_a != last_pos_a, pos_a, "differs from previous pick");
          if (pos_a < 3'd5) hist[pos_a]++;
        end else begin
          check_eq("a_refresh_pos", pos_a, last_pos_a);
        end
        for (int i = 0; i < 5; i++) begin
          if (i == int'(pos_a)) check_eq("a_lit_led", frame_a[i*24 +: 24], e.pix);
          else                  check_eq("a_dark_led", frame_a[i*24 +: 24], 24'h0);
        end
        last_pos_a = pos_a;
      end
    end
  end

  // Monitor B: checks accepted position and frame layout
  always @(negedge clock) begin
    logic [0:0] ep;
    if (rst_b && valid_b && ready_b) begin
      frames_b++;
      check_cond("b_frame_expected", qb.size() != 0, frame_b, "a queued expectation");
      if (qb.size() != 0) begin
        ep = qb.pop_front();
        check_eq("b_pos", pos_b, ep);
        for (int i = 0; i < 2; i++) begin
          if (i == int'(pos_b)) check_eq("b_lit_led", frame_b[i*24 +: 24], 24'h123456);
          else                  check_eq("b_dark_led", frame_b[i*24 +: 24], 24'h0);
        end
      end
    end
  end

  task automatic pick_a(input logic [23:0] pix);
    qa.push_back('{1'b1, pix});
    gj_a = 1'b1;
    step(1);
    gj_a = 1'b0;
  endtask

  task automatic refresh_a(input logic [23:0] pix);
    qa.push_back('{1'b0, pix});
    tick_a = 1'b1;
    step(1);
    tick_a = 1'b0;
  endtask

  task automatic drain_a(input string name);
    int n = 0;
    while ((qa.size() != 0 || busy_a) && n < 200) begin
      step(1);
      n++;
    end
    check_cond(name, n < 200, n, "drained within 200 cycles");
  endtask

  task automatic drain_b(input string name);
    int n = 0;
    while ((qb.size() != 0 || busy_b) && n < 200) begin
      step(1);
      n++;
    end
    check_cond(name, n < 200, n, "drained within 200 cycles");
  endtask

  task automatic timed_pick_b(input logic [0:0] exp_pos, input int exp_lat, input string name);
    int n = 0;
    qb.push_back(exp_pos);
    gj_b = 1'b1;
    step(1);
    gj_b = 1'b0;
    while (!valid_b && n < 50) begin
      step(1);
      n++;
    end
    check_eq(name, n, exp_lat);
    drain_b("b_timed_drain");
  endtask

  initial begin
    int f0;
    int n;
    logic [119:0] held;
    logic [2:0]   hp;

    // reset state
    step(3);
    check_eq("rst_valid_a", valid_a, 1'b0);
    check_eq("rst_frame_a", frame_a, 120'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(100);
    check_eq("idle_frame_a", frame_a, 120'h0);
    check_eq("idle_valid_a", valid_a, 1'b0);
    check_eq("idle_busy_a", busy_a, 1'b0);
    check_eq("idle_pos_a", pos_a, 3'd0);
    check_eq("idle_frame_b", frame_b, 48'h0);
    check_eq("idle_busy_b", busy_b, 1'b0);
    check_eq("idle_pos_b", pos_b, 1'b0);

    // two LEDs with no-repeat must alternate starting from 1
    for (int k = 0; k < 6; k++) begin
      qb.push_back(1'((k + 1) % 2));
      gj_b = 1'b1;
      step(1);
      gj_b = 1'b0;
      drain_b("b_alt_drain");
      step($urandom_range(0, 3));
    end
    check_eq("b_alt_count", frames_b, 6);

    // LFSR held on a rejected candidate: fallback after 16 retries, then a first-try accept
    force dut_b.lfsr = 16'hFFFE;
    timed_pick_b(1'b1, 18, "b_fallback_latency");
    timed_pick_b(1'b0, 2, "b_first_try_latency");
    release dut_b.lfsr;

    // 1000 static picks
    for (int k = 0; k < 1000; k++) begin
      pick_a(24'hFF8040);
      drain_a("a_pick_drain");
      step($urandom_range(0, 3));
    end
    for (int i = 0; i < 5; i++)
      check_cond("a_hist_min", hist[i] >= 100, hist[i], "at least 100");

    // tick in static and mode 11 does nothing; mode 11 picks show raw colour
    f0 = frames_a;
    tick_a = 1'b1;
    step(1);
    tick_a = 1'b0;
    step(3);
    check_eq("static_tick_busy", busy_a, 1'b0);
    modo_a = 2'b11;
    tick_a = 1'b1;
    step(1);
    tick_a = 1'b0;
    step(3);
    check_eq("mode11_tick_frames", frames_a - f0, 0);
    cor_a = 24'h00C3A5;
    pick_a(24'h00C3A5);
    drain_a("mode11_drain");

    // blink: toggles on tick, pick restores phase on
    modo_a = 2'b01;
    cor_a  = 24'hFF8040;
    pick_a(24'hFF8040);   drain_a("blink_drain");
    refresh_a(24'h000000); drain_a("blink_drain");
    pick_a(24'hFF8040);   drain_a("blink_drain");
    refresh_a(24'h000000); drain_a("blink_drain");
    refresh_a(24'hFF8040); drain_a("blink_drain");

    // fade by 64 per tick, saturating at zero
    modo_a = 2'b10;
    pick_a(24'hFF8040);    drain_a("fade_drain");
    refresh_a(24'hBF6030); drain_a("fade_drain");
    refresh_a(24'h7F4020); drain_a("fade_drain");
    refresh_a(24'h3F2010); drain_a("fade_drain");
    refresh_a(24'h000000); drain_a("fade_drain");
    refresh_a(24'h000000); drain_a("fade_drain");
    refresh_a(24'h000000); drain_a("fade_drain");

    // backpressure in fade mode: one pick queued, tick dropped
    ready_a = 1'b0;
    pick_a(24'hFF8040);
    n = 0;
    while (!valid_a && n < 50) begin
      step(1);
      n++;
    end
    check_eq("bp_valid_rise", valid_a, 1'b1);
    held = frame_a;
    hp   = pos_a;
    f0   = frames_a;
    cor_a = 24'h0000FF;
    for (int c = 0; c < 20; c++) begin
      gj_a   = (c == 3 || c == 6);
      tick_a = (c == 9);
      step(1);
      check_eq("bp_valid_held", valid_a, 1'b1);
      check_eq("bp_frame_held", frame_a, held);
      check_eq("bp_pos_held", pos_a, hp);
    end
    gj_a   = 1'b0;
    tick_a = 1'b0;
    qa.push_back('{1'b1, 24'h0000FF});
    ready_a = 1'b1;
    drain_a("bp_drain");
    step(10);
    check_eq("bp_frames_serviced", frames_a - f0, 2);
    check_eq("bp_idle", busy_a, 1'b0);

    // asynchronous reset in WAIT_ACK with a pick pending
    modo_a  = 2'b00;
    cor_a   = 24'hFF8040;
    ready_a = 1'b0;
    pick_a(24'hFF8040);
    n = 0;
    while (!valid_a && n < 50) begin
      step(1);
      n++;
    end
    check_eq("rst_wait_valid", valid_a, 1'b1);
    gj_a = 1'b1;
    step(1);
    gj_a = 1'b0;
    #2 rst_a = 1'b0;
    #1;
    check_eq("async_rst_valid", valid_a, 1'b0);
    check_eq("async_rst_busy", busy_a, 1'b0);
    check_eq("async_rst_frame", frame_a, 120'h0);
    check_eq("async_rst_pos", pos_a, 3'd0);
    ready_a = 1'b1;
    step(2);
    rst_a = 1'b1;
    f0 = frames_a;
    for (int c = 0; c < 4; c++) begin
      step(5);
      check_eq("post_rst_busy", busy_a, 1'b0);
    end
    check_eq("post_rst_frames", frames_a - f0, 0);
    check_eq("post_rst_valid", valid_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
